alu_issue_grf: RTL

Register file plus issue sequencer that sits directly upstream of the combinational `alu`. It accepts one register-register operation at a time and reads both operands from a 32×32 general register file. It drives registered `A`/`B`/`ALUOp` into the ALU, then captures the ALU result `C` and writes it back to the destination register. It also provides a preload port and a debug read port so benches and later datapath stages can seed and inspect register state.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/grf_core.sv | 41 ++++
 rtl/alu_issue_grf.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: op encodings, default widths,
// the issue FSM state type and the reserved-op test.
package alu_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SRL  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;
    localparam logic [2:0] OP_RSV0 = 3'b110;
    localparam logic [2:0] OP_RSV1 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic is_reserved_op(input logic [2:0] op);
        return (op == OP_RSV0) || (op == OP_RSV1);
    endfunction

endpackage

// File: rtl/grf_core.sv
// General register file: 2^AW x DW, three combinational read ports,
// one synchronous write port, register 0 hard-wired to zero.
module grf_core
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    input  logic [AW-1:0] raddr_d,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic [DW-1:0] rdata_d
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Register 0 is masked on read as well, so it is zero regardless of storage.
    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
    assign rdata_d = (raddr_d == '0) ? '0 : mem[raddr_d];

endmodule

// File: rtl/alu_issue_grf.sv
// Register file plus issue sequencer feeding a combinational ALU.
// Define ALU_ISSUE_FAST_EN to drop the WB state (EXEC returns straight to IDLE).
module alu_issue_grf
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic [AW-1:0] in_rd,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_c,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [AW-1:0] dbg_raddr,
    output logic [DW-1:0] dbg_rdata
);

    state_e        state;
    state_e        state_nxt;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic          accept;
    logic          wr_wb;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign wr_wb    = (state == ST_EXEC) && !is_reserved_op(alu_op);

    // Writeback and preload share one write port; they live in different states.
    assign we    = wr_wb || (in_ready && ld_en);
    assign waddr = wr_wb ? rd_q  : ld_addr;
    assign wdata = wr_wb ? alu_c : ld_data;

    grf_core #(
        .DW (DW),
        .AW (AW)
    ) u_grf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (in_rs),
        .raddr_b (in_rt),
        .raddr_d (dbg_raddr),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .rdata_d (dbg_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
`ifdef ALU_ISSUE_FAST_EN
                state_nxt = ST_IDLE;
`else
                state_nxt = ST_WB;
`endif
            end
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= OP_ADD;
            rd_q     <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            if (accept) begin
                alu_a  <= rdata_a;
                alu_b  <= rdata_b;
                alu_op <= in_op;
                rd_q   <= in_rd;
            end
            // wb_valid is a single-cycle pulse after each non-reserved EXEC.
            wb_valid <= wr_wb;
            if (wr_wb) begin
                wb_addr <= rd_q;
                wb_data <= alu_c;
            end
        end
    end

endmodule
